// File: rtl/md_req_queue_if.sv
// md_req_queue_if: issue-side enqueue port and md-unit request/response
// handshake for md_req_queue. The queue binds the slave modport; whatever
// drives requests in and plays the md unit binds the master modport.
interface md_req_queue_if #(
  parameter int DEPTH   = 4,
  parameter int XPR_LEN = 32,
  parameter int OP_W    = 2,
  parameter int SEL_W   = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Enqueue side (from pipeline issue)
  logic               enq_valid;
  logic               enq_ready;
  logic               enq_in_1_signed;
  logic               enq_in_2_signed;
  logic [OP_W-1:0]    enq_op;
  logic [SEL_W-1:0]   enq_out_sel;
  logic [XPR_LEN-1:0] enq_in_1;
  logic [XPR_LEN-1:0] enq_in_2;

  // Request side (to md unit)
  logic               req_valid;
  logic               req_ready;
  logic               req_in_1_signed;
  logic               req_in_2_signed;
  logic [OP_W-1:0]    req_op;
  logic [SEL_W-1:0]   req_out_sel;
  logic [XPR_LEN-1:0] req_in_1;
  logic [XPR_LEN-1:0] req_in_2;

  // Response retirement and status
  logic               resp_valid;
  logic [CNT_W-1:0]   count;
  logic               busy;

  modport slave (
    input  enq_valid, enq_in_1_signed, enq_in_2_signed, enq_op, enq_out_sel,
           enq_in_1, enq_in_2, req_ready, resp_valid,
    output enq_ready, req_valid, req_in_1_signed, req_in_2_signed, req_op,
           req_out_sel, req_in_1, req_in_2, count, busy
  );

  modport master (
    output enq_valid, enq_in_1_signed, enq_in_2_signed, enq_op, enq_out_sel,
           enq_in_1, enq_in_2, req_ready, resp_valid,
    input  enq_ready, req_valid, req_in_1_signed, req_in_2_signed, req_op,
           req_out_sel, req_in_1, req_in_2, count, busy
  );
endinterface

// File: rtl/md_req_queue.sv
// md_req_queue: DEPTH-entry FIFO in front of the multiply/divide unit.
// Presents the head entry on the req_* handshake and allows only one
// operation in flight: after an issue, the next request waits until
// resp_valid retires the current one.
// Optional feature macro MD_REQ_QUEUE_STATS_EN adds issue_cnt/stall_cnt
// performance counters; without it those ports do not exist.
module md_req_queue #(
  parameter int DEPTH   = 4,
  parameter int XPR_LEN = 32,
  parameter int OP_W    = 2,
  parameter int SEL_W   = 2
) (
  input  logic        clk,
  input  logic        reset,   // asynchronous, active-low
  md_req_queue_if.slave q
`ifdef MD_REQ_QUEUE_STATS_EN
  ,
  output logic [31:0] issue_cnt,
  output logic [31:0] stall_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  // In-flight tracker: IDLE may issue, INFLIGHT waits for resp_valid.
  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] INFLIGHT = 1'b1;

  typedef struct packed {
    logic               in_1_signed;
    logic               in_2_signed;
    logic [OP_W-1:0]    op;
    logic [SEL_W-1:0]   out_sel;
    logic [XPR_LEN-1:0] in_1;
    logic [XPR_LEN-1:0] in_2;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             enq_entry;
  entry_t             head;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [0:0]         state_q, state_d;
  logic               push;
  logic               issue;
  logic               req_valid;

  assign enq_entry = '{
    in_1_signed: q.enq_in_1_signed,
    in_2_signed: q.enq_in_2_signed,
    op:          q.enq_op,
    out_sel:     q.enq_out_sel,
    in_1:        q.enq_in_1,
    in_2:        q.enq_in_2
  };

  // Handshake qualifiers; enq_ready looks only at registered occupancy so it
  // never depends on a same-cycle dequeue.
  assign q.enq_ready = (count_q != FULL);
  assign req_valid   = (count_q != '0) && (state_q == IDLE);
  assign push        = q.enq_valid && q.enq_ready;
  assign issue       = req_valid && q.req_ready;

  // Head entry straight from storage: req_* only change on a clock edge.
  assign head              = mem_q[rd_ptr_q];
  assign q.req_valid       = req_valid;
  assign q.req_in_1_signed = head.in_1_signed;
  assign q.req_in_2_signed = head.in_2_signed;
  assign q.req_op          = head.op;
  assign q.req_out_sel     = head.out_sel;
  assign q.req_in_1        = head.in_1;
  assign q.req_in_2        = head.in_2;
  assign q.count           = count_q;
  assign q.busy            = (state_q == INFLIGHT);

  // Next-state for pointers, occupancy and the in-flight tracker.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    if (push)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (issue) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, issue})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    case (state_q)
      IDLE:     if (issue)        state_d = INFLIGHT;
      INFLIGHT: if (q.resp_valid) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Control registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

  // Entry storage, written at the tail on each accepted push.
  // NOTE: storage is reset because req_* must read zero out of reset; this
  // keeps the array in flops rather than a RAM macro.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= enq_entry;
    end
  end

`ifdef MD_REQ_QUEUE_STATS_EN
  logic [31:0] issue_cnt_q;
  logic [31:0] stall_cnt_q;

  // Performance counters: issues, and cycles with work queued behind an
  // in-flight op. Both wrap naturally at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (issue) issue_cnt_q <= issue_cnt_q + 32'd1;
      if ((count_q != '0) && (state_q == INFLIGHT)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign issue_cnt = issue_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_md_req_queue.sv
// tb_md_req_queue: directed vector table for md_req_queue plus hand-written
// sequences for reset mid-operation, ordering across pointer wrap with
// random md latency, and (with MD_REQ_QUEUE_STATS_EN) the stats counters.
module tb_md_req_queue;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  md_req_queue_if #(.DEPTH(4), .XPR_LEN(32), .OP_W(2), .SEL_W(2)) bus ();

`ifdef MD_REQ_QUEUE_STATS_EN
  logic [31:0] issue_cnt;
  logic [31:0] stall_cnt;
`endif

  md_req_queue #(.DEPTH(4), .XPR_LEN(32), .OP_W(2), .SEL_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (bus.slave)
`ifdef MD_REQ_QUEUE_STATS_EN
    ,
    .issue_cnt (issue_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ev, input logic [1:0] op, input logic [31:0] i1,
                       input logic [31:0] i2, input logic rr, input logic rv);
    bus.enq_valid       = ev;
    bus.enq_op          = op;
    bus.enq_out_sel     = op;
    bus.enq_in_1_signed = op[0];
    bus.enq_in_2_signed = op[1];
    bus.enq_in_1        = i1;
    bus.enq_in_2        = i2;
    bus.req_ready       = rr;
    bus.resp_valid      = rv;
  endtask

  typedef struct {
    logic        ev;
    logic [1:0]  op;
    logic [31:0] i1;
    logic [31:0] i2;
    logic        rr;
    logic        rv;
    logic        e_rdy;
    logic        e_rv;
    logic [1:0]  e_op;
    logic [31:0] e_i1;
    logic [31:0] e_i2;
    logic [2:0]  e_cnt;
    logic        e_busy;
  } vec_t;

  function automatic vec_t mk(logic ev, logic [1:0] op, logic [31:0] i1, logic [31:0] i2,
                              logic rr, logic rv, logic e_rdy, logic e_rv, logic [1:0] e_op,
                              logic [31:0] e_i1, logic [31:0] e_i2, logic [2:0] e_cnt,
                              logic e_busy);
    vec_t v;
    v.ev = ev; v.op = op; v.i1 = i1; v.i2 = i2; v.rr = rr; v.rv = rv;
    v.e_rdy = e_rdy; v.e_rv = e_rv; v.e_op = e_op; v.e_i1 = e_i1; v.e_i2 = e_i2;
    v.e_cnt = e_cnt; v.e_busy = e_busy;
    return v;
  endfunction

  // Push/issue/retire n tagged ops against a behavioural model; each row of
  // expectations is the state before the coming rising edge. lat < 0 picks a
  // random 1..8 cycle md latency per op, otherwise the latency is lat+1.
  task automatic run_ops(input int n, input string tag, input int lat);
    int next_push  = 0;
    int next_issue = 0;
    int m_count    = 0;
    bit m_inflight = 0;
    int m_lat      = 0;
    int cycles     = 0;
    bit exp_rv;
    bit do_push;
    bit rv;
    while (!(next_issue == n && !m_inflight) || cycles == 0) begin
      @(negedge clk);
      rv = m_inflight && (m_lat == 0);
      drive(next_push < n, 2'(next_push), 32'(next_push), 32'(next_push + 500), 1'b1, rv);
      #1;
      exp_rv  = (m_count != 0) && !m_inflight;
      do_push = (next_push < n) && (m_count != 4);
      check($sformatf("%s.c%0d.busy", tag, cycles), bus.busy, m_inflight);
      check($sformatf("%s.c%0d.req_valid", tag, cycles), bus.req_valid, exp_rv);
      check($sformatf("%s.c%0d.enq_ready", tag, cycles), bus.enq_ready, m_count != 4);
      if (exp_rv) check($sformatf("%s.c%0d.order", tag, cycles), bus.req_in_1, next_issue);
      if (do_push) begin next_push++; m_count++; end
      if (exp_rv) begin
        next_issue++;
        m_count--;
        m_inflight = 1;
        m_lat = (lat < 0) ? int'($urandom_range(0, 7)) : lat;
      end else if (rv) begin
        m_inflight = 0;
      end else if (m_inflight && m_lat != 0) begin
        m_lat--;
      end
      cycles++;
      if (cycles > 2000) begin
        check({tag, ".timeout"}, 1'b1, 1'b0);
        break;
      end
    end
    @(negedge clk);
    drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    check({tag, ".drained_count"}, bus.count, 3'd0);
    check({tag, ".drained_busy"}, bus.busy, 1'b0);
  endtask

  vec_t vecs [27];

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);

    //         ev op  i1  i2  rr rv | rdy rv op  i1  i2  cnt busy
    vecs[0]  = mk(1, 1,  7,  6, 1, 0,  1, 0, 0,  0,  0, 0, 0);
    vecs[1]  = mk(0, 0,  0,  0, 1, 0,  1, 1, 1,  7,  6, 1, 0);
    vecs[2]  = mk(0, 0,  0,  0, 1, 0,  1, 0, 0,  0,  0, 0, 1);
    vecs[3]  = mk(0, 0,  0,  0, 1, 0,  1, 0, 0,  0,  0, 0, 1);
    vecs[4]  = mk(0, 0,  0,  0, 1, 0,  1, 0, 0,  0,  0, 0, 1);
    vecs[5]  = mk(0, 0,  0,  0, 1, 0,  1, 0, 0,  0,  0, 0, 1);
    vecs[6]  = mk(0, 0,  0,  0, 1, 1,  1, 0, 0,  0,  0, 0, 1);
    vecs[7]  = mk(1, 0, 10, 110, 0, 0, 1, 0, 0,  0,  0, 0, 0);
    vecs[8]  = mk(1, 1, 11, 111, 0, 0, 1, 1, 0, 10, 110, 1, 0);
    vecs[9]  = mk(1, 2, 12, 112, 0, 0, 1, 1, 0, 10, 110, 2, 0);
    vecs[10] = mk(1, 3, 13, 113, 0, 0, 1, 1, 0, 10, 110, 3, 0);
    vecs[11] = mk(1, 0, 14, 114, 0, 0, 0, 1, 0, 10, 110, 4, 0);
    vecs[12] = mk(0, 0,  0,  0, 0, 0,  0, 1, 0, 10, 110, 4, 0);
    vecs[13] = mk(0, 0,  0,  0, 1, 0,  0, 1, 0, 10, 110, 4, 0);
    vecs[14] = mk(0, 0,  0,  0, 1, 1,  1, 0, 0,  0,  0, 3, 1);
    vecs[15] = mk(0, 0,  0,  0, 1, 0,  1, 1, 1, 11, 111, 3, 0);
    vecs[16] = mk(0, 0,  0,  0, 0, 1,  1, 0, 0,  0,  0, 2, 1);
    vecs[17] = mk(1, 2, 20, 120, 1, 0, 1, 1, 2, 12, 112, 2, 0);
    vecs[18] = mk(0, 0,  0,  0, 0, 0,  1, 0, 0,  0,  0, 2, 1);
    vecs[19] = mk(0, 0,  0,  0, 0, 1,  1, 0, 0,  0,  0, 2, 1);
    vecs[20] = mk(0, 0,  0,  0, 0, 1,  1, 1, 3, 13, 113, 2, 0);
    vecs[21] = mk(0, 0,  0,  0, 0, 1,  1, 1, 3, 13, 113, 2, 0);
    vecs[22] = mk(0, 0,  0,  0, 1, 0,  1, 1, 3, 13, 113, 2, 0);
    vecs[23] = mk(0, 0,  0,  0, 0, 1,  1, 0, 0,  0,  0, 1, 1);
    vecs[24] = mk(0, 0,  0,  0, 1, 0,  1, 1, 2, 20, 120, 1, 0);
    vecs[25] = mk(0, 0,  0,  0, 0, 1,  1, 0, 0,  0,  0, 0, 1);
    vecs[26] = mk(0, 0,  0,  0, 0, 0,  1, 0, 0,  0,  0, 0, 0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst.count", bus.count, 3'd0);
    check("rst.busy", bus.busy, 1'b0);
    check("rst.req_valid", bus.req_valid, 1'b0);
    check("rst.enq_ready", bus.enq_ready, 1'b1);
    check("rst.req_in_1", bus.req_in_1, 32'd0);
    check("rst.req_op", bus.req_op, 2'd0);
    @(negedge clk);
    reset = 1'b1;

    // Vector table: single op, fill/overflow, push+issue, spurious resp
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      drive(vecs[i].ev, vecs[i].op, vecs[i].i1, vecs[i].i2, vecs[i].rr, vecs[i].rv);
      #1;
      check($sformatf("v%0d.enq_ready", i), bus.enq_ready, vecs[i].e_rdy);
      check($sformatf("v%0d.req_valid", i), bus.req_valid, vecs[i].e_rv);
      check($sformatf("v%0d.count", i), bus.count, vecs[i].e_cnt);
      check($sformatf("v%0d.busy", i), bus.busy, vecs[i].e_busy);
      if (vecs[i].e_rv) begin
        check($sformatf("v%0d.req_in_1", i), bus.req_in_1, vecs[i].e_i1);
        check($sformatf("v%0d.req_in_2", i), bus.req_in_2, vecs[i].e_i2);
        check($sformatf("v%0d.req_op", i), bus.req_op, vecs[i].e_op);
        check($sformatf("v%0d.req_out_sel", i), bus.req_out_sel, vecs[i].e_op);
        check($sformatf("v%0d.req_s1", i), bus.req_in_1_signed, vecs[i].e_op[0]);
        check($sformatf("v%0d.req_s2", i), bus.req_in_2_signed, vecs[i].e_op[1]);
      end
    end

    // Reset mid-operation: two pushes, one issue, then async reset
    @(negedge clk);
    drive(1'b1, 2'd1, 32'd30, 32'd31, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 2'd2, 32'd32, 32'd33, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    check("mid.count_pre", bus.count, 3'd1);
    check("mid.busy_pre", bus.busy, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    check("mid.count", bus.count, 3'd0);
    check("mid.busy", bus.busy, 1'b0);
    check("mid.req_valid", bus.req_valid, 1'b0);
    check("mid.enq_ready", bus.enq_ready, 1'b1);
    check("mid.req_in_1", bus.req_in_1, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Ordering across pointer wrap with random md latency 1..8
    run_ops(10, "ord", -1);

`ifdef MD_REQ_QUEUE_STATS_EN
    // Stats: 3 ops, 4-cycle latency, queue backlogged behind the first two.
    // Backlogged busy cycles: 4 behind op0 plus 4 behind op1 = 8.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("stats.issue_rst", issue_cnt, 32'd0);
    check("stats.stall_rst", stall_cnt, 32'd0);
    run_ops(3, "stats", 3);
    check("stats.issue_cnt", issue_cnt, 32'd3);
    check("stats.stall_cnt", stall_cnt, 32'd8);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
